// File: rtl/vector_cache_pkg.sv
// Shared types and sizing for the vector cache write-data-buffer path.
package vector_cache_pkg;

    localparam int unsigned WDB_ENTRY_NUM        = 16;
    localparam int unsigned WDB_IDX_W            = $clog2(WDB_ENTRY_NUM);
    localparam int unsigned WDB_RD_LAT           = 2;
    localparam int unsigned WR_DONE_DELAY        = 4;
    localparam int unsigned TXNID_W              = 8;
    localparam int unsigned MSHR_ENTRY_IDX_WIDTH = 5;

    typedef struct packed {
        logic [WDB_IDX_W-1:0]            db_entry_id;
        logic [TXNID_W-1:0]              txnid;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    } wdb_req_t;

    // WDB address carries the same id tuple as the request payload
    typedef wdb_req_t wdb_addr_t;

    typedef enum logic [1:0] {
        ENT_FREE  = 2'd0,
        ENT_ALLOC = 2'd1,
        ENT_FULL  = 2'd2,
        ENT_DRAIN = 2'd3
    } wdb_ent_state_e;

endpackage

// File: rtl/wdb_free_list.sv
// Per-entry WDB lifecycle state and lowest-free entry offer.
// VEC_CACHE_WDB_OCC_CNT_EN adds the non-free occupancy counter.
module wdb_free_list
    import vector_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_rdy,
    input  logic                 fill_hs,
    input  logic [WDB_IDX_W-1:0] fill_idx,
    input  logic                 drain_hs,
    input  logic [WDB_IDX_W-1:0] drain_idx,
    input  logic                 rel_vld,
    input  logic [WDB_IDX_W-1:0] rel_idx,
    output logic                 alloc_vld,
    output logic [WDB_IDX_W-1:0] alloc_idx
`ifdef VEC_CACHE_WDB_OCC_CNT_EN
    ,
    output logic [WDB_IDX_W:0]   occ
`endif
);

    wdb_ent_state_e state     [WDB_ENTRY_NUM];
    wdb_ent_state_e state_nxt [WDB_ENTRY_NUM];
    logic           alloc_fire;
    logic           rel_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WDB_ENTRY_NUM); i++) state[i] <= ENT_FREE;
        end else begin
            for (int i = 0; i < int'(WDB_ENTRY_NUM); i++) state[i] <= state_nxt[i];
        end
    end

    // Lowest-index free entry wins the offer
    always_comb begin
        alloc_vld = 1'b0;
        alloc_idx = '0;
        for (int i = int'(WDB_ENTRY_NUM) - 1; i >= 0; i--) begin
            if (state[i] == ENT_FREE) begin
                alloc_vld = 1'b1;
                alloc_idx = WDB_IDX_W'(i);
            end
        end
    end

    assign alloc_fire = alloc_vld & alloc_rdy;
    assign rel_fire   = rel_vld & (state[rel_idx] == ENT_DRAIN);

    // Illegal fills/drains leave the entry untouched
    always_comb begin
        for (int i = 0; i < int'(WDB_ENTRY_NUM); i++) state_nxt[i] = state[i];
        if (alloc_fire) state_nxt[alloc_idx] = ENT_ALLOC;
        if (fill_hs && state[fill_idx] == ENT_ALLOC) state_nxt[fill_idx] = ENT_FULL;
        if (drain_hs && state[drain_idx] == ENT_FULL) state_nxt[drain_idx] = ENT_DRAIN;
        if (rel_fire) state_nxt[rel_idx] = ENT_FREE;
    end

`ifdef VEC_CACHE_WDB_OCC_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (alloc_fire && !rel_fire) begin
            occ <= occ + 1'b1;
        end else if (rel_fire && !alloc_fire) begin
            occ <= occ - 1'b1;
        end
    end
`endif

    fill_to_alloc_entry: assert property (@(posedge clk) disable iff (rst)
        fill_hs |-> state[fill_idx] == ENT_ALLOC)
        else $error("wdb fill to entry that is not allocated");

    drain_of_full_entry: assert property (@(posedge clk) disable iff (rst)
        drain_hs |-> state[drain_idx] == ENT_FULL)
        else $error("wdb drain of entry that is not full");

endmodule

// File: rtl/wdb_agent.sv
// Write-data-buffer agent: allocates WDB entries, fills them, drains them to the data ram.
// VEC_CACHE_WDB_OCC_CNT_EN exposes wdb_occ (non-free entry count).
module wdb_agent
    import vector_cache_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    output logic                            alloc_vld,
    output logic [WDB_IDX_W-1:0]            alloc_idx,
    input  logic                            alloc_rdy,
    input  logic                            us_wr_vld,
    input  wdb_req_t                        us_wr_pld,
    output logic                            us_wr_rdy,
    input  logic                            dataram_wr_vld,
    input  wdb_req_t                        dataram_wr_pld,
    output logic                            dataram_wr_rdy,
    output logic                            wdb_mem_en,
    output logic                            wdb_wr_en,
    output wdb_addr_t                       wdb_addr,
    output logic                            ram_wr_vld,
    output wdb_req_t                        ram_wr_pld,
    output logic                            wr_done,
    output logic [MSHR_ENTRY_IDX_WIDTH-1:0] wr_done_idx
`ifdef VEC_CACHE_WDB_OCC_CNT_EN
    ,
    output logic [WDB_IDX_W:0]              wdb_occ
`endif
);

    logic                     fill_hs;
    logic                     drain_hs;
    logic [WR_DONE_DELAY-1:0] pipe_vld;
    wdb_req_t                 pipe_pld [WR_DONE_DELAY];

    // Single-ported WDB: fills always win, drains wait for an idle port
    assign us_wr_rdy      = 1'b1;
    assign dataram_wr_rdy = ~us_wr_vld;
    assign fill_hs        = us_wr_vld & us_wr_rdy;
    assign drain_hs       = dataram_wr_vld & dataram_wr_rdy;
    assign wdb_mem_en     = fill_hs | drain_hs;
    assign wdb_wr_en      = fill_hs;

    always_comb begin
        wdb_addr = '0;
        if (fill_hs) begin
            wdb_addr = us_wr_pld;
        end else if (drain_hs) begin
            wdb_addr = dataram_wr_pld;
        end
    end

    // Tracks WDB read latency and the later write-done point for each drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < int'(WR_DONE_DELAY); i++) pipe_pld[i] <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[WR_DONE_DELAY-2:0], drain_hs};
            pipe_pld[0] <= dataram_wr_pld;
            for (int i = 1; i < int'(WR_DONE_DELAY); i++) pipe_pld[i] <= pipe_pld[i-1];
        end
    end

    assign ram_wr_vld  = pipe_vld[WDB_RD_LAT-1];
    assign ram_wr_pld  = pipe_pld[WDB_RD_LAT-1];
    assign wr_done     = pipe_vld[WR_DONE_DELAY-1];
    assign wr_done_idx = pipe_pld[WR_DONE_DELAY-1].rob_entry_id;

    wdb_free_list u_free_list (
        .clk       (clk),
        .rst       (rst),
        .alloc_rdy (alloc_rdy),
        .fill_hs   (fill_hs),
        .fill_idx  (us_wr_pld.db_entry_id),
        .drain_hs  (drain_hs),
        .drain_idx (dataram_wr_pld.db_entry_id),
        .rel_vld   (ram_wr_vld),
        .rel_idx   (ram_wr_pld.db_entry_id),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx)
`ifdef VEC_CACHE_WDB_OCC_CNT_EN
        ,
        .occ       (wdb_occ)
`endif
    );

endmodule
